spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Transaction sequencer and arbiter in front of the 16-bit SPIMaster.
- Shares one SPIMaster between NUM_REQ requesters using round-robin arbitration.
- Owns chip select: drives CS_n low with setup/hold/gap timing around each multi-word burst.
- Feeds TX words to the master one at a time through its TX_DV/TX_Ready handshake and returns each RX word to the granted requester.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
LEN_W, 4, width of per-requester length field; burst length = field+1 words (1..16).
CS_SETUP_CLKS, 4, i_Clk cycles from CS_n falling to first o_M_TX_DV.
CS_HOLD_CLKS, 4, i_Clk cycles after last word completes before CS_n rises.
CS_GAP_CLKS, 8, minimum CS_n-high cycles between bursts.
TIMEOUT_CLKS, 256, watchdog limit per word (optional feature only).

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  async active-low reset
i_Req  in  NUM_REQ  request level per requester; held until o_Done for that requester
i_Len  in  NUM_REQ*LEN_W  flattened burst lengths (words-1); sampled at grant
i_TX_Word  in  NUM_REQ*16  flattened next TX word per requester
o_Grant  out  NUM_REQ  one-hot; high for the whole burst
o_TX_Pop  out  1  pulse: granted requester must present its next word next cycle
o_RX_DV  out  1  one-cycle pulse, RX word valid
o_RX_Word  out  16  received word
o_Done  out  1  one-cycle pulse when CS_n has risen after a burst
o_Err  out  1  one-cycle abort pulse (optional feature only, else tied 0)
o_M_TX_Byte  out  16  to SPIMaster i_TX_Byte
o_M_TX_DV  out  1  to SPIMaster i_TX_DV
i_M_TX_Ready  in  1  from SPIMaster o_TX_Ready
i_M_RX_DV  in  1  from SPIMaster o_RX_DV
i_M_RX_Byte  in  16  from SPIMaster o_RX_Byte
o_SPI_CS_n  out  1  chip select, active low

Behaviour:
- Reset values: o_SPI_CS_n=1; state=IDLE; RR pointer=0; all other outputs 0.
- IDLE: when any i_Req is set, grant the first set bit at or after the RR pointer, searching upward with wrap. In the same cycle, register o_Grant and latch len=i_Len slice; go to SETUP with CS_n=0.
- SETUP: count CS_SETUP_CLKS, then go to LOAD.
- LOAD: wait for i_M_TX_Ready=1. Then pulse o_M_TX_DV for one cycle, with o_M_TX_Byte=granted i_TX_Word and o_TX_Pop=1. Go to XFER.
- XFER: wait for i_M_RX_DV. In that cycle, o_RX_DV=1 and o_RX_Word=i_M_RX_Byte (registered, 1-cycle latency).
  - If words remain: decrement and go to LOAD. LOAD re-waits for TX_Ready, which rises after RX_DV.
  - Otherwise go to HOLD.
- HOLD: count CS_HOLD_CLKS, then CS_n=1, pulse o_Done, and advance RR pointer to granted index+1 (mod NUM_REQ). Go to GAP.
- GAP: count CS_GAP_CLKS with o_Grant=0, then go to IDLE.
- Requests are never preempted. A request dropped mid-burst is ignored; the burst completes.
- i_Req changes during a burst have no effect until IDLE.
- Word counter is LEN_W+1 bits; len field 0 gives a 1-word burst, all-ones gives 2^LEN_W words.
- Async reset mid-burst: CS_n rises immediately and all state clears. SPIMaster shares the reset, so no handshake is pending afterwards.
- o_M_TX_DV is never asserted while i_M_TX_Ready=0.

Optional Feature:
Macro: SPI_XFER_TIMEOUT_EN.
- Defined: a counter runs in LOAD and XFER and restarts on each state entry.
  - Reaching TIMEOUT_CLKS aborts the burst: CS_n=1 at once, o_Err pulses one cycle, no o_Done.
  - RR pointer advances as in HOLD; next state is GAP.
- Undefined: no counter; o_Err is constant 0; the block waits indefinitely.

Decomposition:
Package spi_xfer_pkg:
- State enum {IDLE, SETUP, LOAD, XFER, HOLD, GAP}.
- Word width constant 16.
Sub-module spi_rr_arbiter:
- Parameterised NUM_REQ.
- Inputs: request vector, pointer.
- Output: one-hot grant plus index.
- Combinational pick, registered by the parent.

Test Plan:
- Single requester 0, len=0, TX 16'hA5C3, MISO looped to MOSI → CS_n low, one o_M_TX_DV, o_RX_Word=16'hA5C3, o_Done once, CS_n low for ≥ SETUP+transfer+HOLD cycles.
- Requester 1, len=3, words 16'h0001..16'h0004 → exactly 4 o_TX_Pop, 4 o_RX_DV in order, CS_n continuously low across all words.
- Both requesters held high for 3 bursts each → grants 0,1,0,1,0,1; CS_n high ≥ 8 cycles between bursts.
- Assert i_Rst_L low during word 2 of a 4-word burst → CS_n=1 and outputs at reset values at once; after release, a new request completes normally.
- Force i_M_TX_Ready=0 for 50 cycles in LOAD → o_M_TX_DV stays 0 until Ready rises, then exactly one pulse.
- With SPI_XFER_TIMEOUT_EN, suppress i_M_RX_DV → o_Err after 256 cycles, CS_n=1, no o_Done, next requester granted after GAP.

Source files
------------

// File: rtl/spi_xfer_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
// Holds the burst FSM state encoding and the SPI word width.
package spi_xfer_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    XFER,
    HOLD,
    GAP
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Word-level handshake bundle between the sequencer and the SPIMaster.
// The sequencer side takes the master modport.
interface spi_xfer_ctrl_if;
  import spi_xfer_pkg::*;

  logic [WORD_W-1:0] tx_byte;
  logic              tx_dv;
  logic              tx_ready;
  logic              rx_dv;
  logic [WORD_W-1:0] rx_byte;

  modport master (
    output tx_byte,
    output tx_dv,
    input  tx_ready,
    input  rx_dv,
    input  rx_byte
  );

  modport slave (
    input  tx_byte,
    input  tx_dv,
    output tx_ready,
    output rx_dv,
    output rx_byte
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, with wrap.
// Purely combinational; the parent registers the result.
module spi_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
        valid_o = 1'b1;
        gnt_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Burst sequencer/arbiter sharing one 16-bit SPIMaster between requesters.
// Define SPI_XFER_TIMEOUT_EN to add the per-word watchdog and o_Err.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int LEN_W         = 4,
  parameter int CS_SETUP_CLKS = 4,
  parameter int CS_HOLD_CLKS  = 4,
  parameter int CS_GAP_CLKS   = 8,
  parameter int TIMEOUT_CLKS  = 256
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic [NUM_REQ-1:0]        i_Req,
  input  logic [NUM_REQ*LEN_W-1:0]  i_Len,
  input  logic [NUM_REQ*WORD_W-1:0] i_TX_Word,
  output logic [NUM_REQ-1:0]        o_Grant,
  output logic                      o_TX_Pop,
  output logic                      o_RX_DV,
  output logic [WORD_W-1:0]         o_RX_Word,
  output logic                      o_Done,
  output logic                      o_Err,
  output logic                      o_SPI_CS_n,
  spi_xfer_ctrl_if.master           m
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX  = max2(max2(CS_SETUP_CLKS, CS_HOLD_CLKS),
                              max2(CS_GAP_CLKS, TIMEOUT_CLKS));
  localparam int TMR_W = $clog2(TMAX + 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [LEN_W:0]      words_q, words_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                cs_n_q, cs_n_d;
  logic                done_q, done_d;
  logic                rx_dv_q, rx_dv_d;
  logic [WORD_W-1:0]   rx_word_q, rx_word_d;
`ifdef SPI_XFER_TIMEOUT_EN
  logic                err_q, err_d;
`endif

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_vld;
  logic [IDX_W-1:0]    rr_nxt;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (i_Req),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_vld)
  );

  assign rr_nxt = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
  assign m.tx_byte = i_TX_Word[int'(idx_q)*WORD_W +: WORD_W];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    words_d   = words_q;
    tmr_d     = tmr_q + 1'b1;
    cs_n_d    = cs_n_q;
    done_d    = 1'b0;
    rx_dv_d   = 1'b0;
    rx_word_d = rx_word_q;
    m.tx_dv   = 1'b0;
    o_TX_Pop  = 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (arb_vld) begin
        grant_d = arb_gnt;
        idx_d   = arb_idx;
        words_d = {1'b0, i_Len[int'(arb_idx)*LEN_W +: LEN_W]};
        cs_n_d  = 1'b0;
        tmr_d   = '0;
        state_d = SETUP;
      end
      SETUP: if (tmr_q == TMR_W'(CS_SETUP_CLKS - 1)) begin
        tmr_d   = '0;
        state_d = LOAD;
      end
      LOAD: if (m.tx_ready) begin
        m.tx_dv  = 1'b1;
        o_TX_Pop = 1'b1;
        tmr_d    = '0;
        state_d  = XFER;
      end
      XFER: if (m.rx_dv) begin
        rx_dv_d   = 1'b1;
        rx_word_d = m.rx_byte;
        tmr_d     = '0;
        if (words_q != '0) begin
          words_d = words_q - 1'b1;
          state_d = LOAD;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: if (tmr_q == TMR_W'(CS_HOLD_CLKS - 1)) begin
        cs_n_d  = 1'b1;
        done_d  = 1'b1;
        rr_d    = rr_nxt;
        grant_d = '0;
        tmr_d   = '0;
        state_d = GAP;
      end
      GAP: if (tmr_q == TMR_W'(CS_GAP_CLKS - 1)) begin
        tmr_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_XFER_TIMEOUT_EN
    // A word that stalls in LOAD or XFER aborts the whole burst.
    if ((state_q == LOAD || state_q == XFER) && state_d == state_q &&
        tmr_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
      cs_n_d  = 1'b1;
      err_d   = 1'b1;
      rr_d    = rr_nxt;
      grant_d = '0;
      tmr_d   = '0;
      state_d = GAP;
    end
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      rr_q      <= '0;
      words_q   <= '0;
      tmr_q     <= '0;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
      rx_dv_q   <= 1'b0;
      rx_word_q <= '0;
`ifdef SPI_XFER_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      words_q   <= words_d;
      tmr_q     <= tmr_d;
      cs_n_q    <= cs_n_d;
      done_q    <= done_d;
      rx_dv_q   <= rx_dv_d;
      rx_word_q <= rx_word_d;
`ifdef SPI_XFER_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign o_Grant    = grant_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Word  = rx_word_q;
  assign o_Done     = done_q;
  assign o_SPI_CS_n = cs_n_q;
`ifdef SPI_XFER_TIMEOUT_EN
  assign o_Err      = err_q;
`else
  assign o_Err      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a loopback SPIMaster model.
// Define SPI_XFER_TIMEOUT_EN to also exercise the watchdog abort.
module tb_spi_xfer_ctrl;
  import spi_xfer_pkg::*;

  localparam int NR = 2;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req;
  logic [NR*LW-1:0] len;
  logic [NR*16-1:0] txw;
  logic [NR-1:0]    grant;
  logic             pop, rxdv, done, err, csn;
  logic [15:0]      rxw;

  spi_xfer_ctrl_if m_if ();

  spi_xfer_ctrl dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Req      (req),
    .i_Len      (len),
    .i_TX_Word  (txw),
    .o_Grant    (grant),
    .o_TX_Pop   (pop),
    .o_RX_DV    (rxdv),
    .o_RX_Word  (rxw),
    .o_Done     (done),
    .o_Err      (err),
    .o_SPI_CS_n (csn),
    .m          (m_if)
  );

  // SPIMaster model: MISO looped to MOSI, fixed word time
  logic        busy, block_ready, suppress_rx;
  int          mcnt;
  logic [15:0] shreg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_if.tx_ready <= 1'b1;
      m_if.rx_dv    <= 1'b0;
      m_if.rx_byte  <= '0;
      busy          <= 1'b0;
      mcnt          <= 0;
      shreg         <= '0;
    end else begin
      m_if.rx_dv <= 1'b0;
      if (m_if.tx_dv) begin
        busy          <= 1'b1;
        mcnt          <= 5;
        shreg         <= m_if.tx_byte;
        m_if.tx_ready <= 1'b0;
      end else if (busy) begin
        if (mcnt != 0) mcnt <= mcnt - 1;
        else if (!suppress_rx) begin
          m_if.rx_dv   <= 1'b1;
          m_if.rx_byte <= shreg;
          busy         <= 1'b0;
        end
      end else begin
        m_if.tx_ready <= !block_ready;
      end
    end
  end

  // Requesters: word = base + number of pops so far
  logic [15:0] base [NR];
  int          pop_cnt [NR] = '{default: 0};

  always @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (pop && grant[i]) pop_cnt[i] <= pop_cnt[i] + 1;

  always_comb begin
    txw = '0;
    for (int i = 0; i < NR; i++)
      txw[i*16 +: 16] = base[i] + 16'(pop_cnt[i]);
  end

  // Monitors
  int n_txdv = 0, n_pop = 0, n_done = 0, n_rise = 0, viol = 0;
  int lowrun = 0, highrun = 0, last_low = 0;
  logic prev_csn = 1'b1;
  logic [NR-1:0] prev_grant = '0;
  logic [15:0]   rx_log [$];
  logic [NR-1:0] gnt_log [$];
  int            hrun_log [$];

  always @(posedge clk) begin
    if (m_if.tx_dv) n_txdv++;
    if (m_if.tx_dv && !m_if.tx_ready) viol++;
    if (pop) n_pop++;
    if (rxdv) rx_log.push_back(rxw);
    if (done) n_done++;
    if (grant != '0 && prev_grant == '0) gnt_log.push_back(grant);
    prev_grant = grant;
    if (csn) begin
      if (!prev_csn) begin
        n_rise++;
        last_low = lowrun;
      end
      highrun++;
      lowrun = 0;
    end else begin
      if (prev_csn) hrun_log.push_back(highrun);
      lowrun++;
      highrun = 0;
    end
    prev_csn = csn;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rx_at(input int i);
    if (i < rx_log.size()) return rx_log[i];
    return 16'hxxxx;
  endfunction

  function automatic logic [NR-1:0] gnt_at(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return 'x;
  endfunction

  task automatic wait_done(input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("done_count", seen, n);
  endtask

  task automatic wait_txdv(input int target, input int budget);
    for (int c = 0; c < budget && n_txdv < target; c++)
      @(negedge clk);
    check("txdv_reached", 32'(n_txdv >= target), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int a_tx, a_pop, a_rx, a_g, a_h, a_rise, a_done;

  initial begin
    req = '0;
    len = '0;
    base[0] = '0;
    base[1] = '0;
    block_ready = 1'b0;
    suppress_rx = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_csn", csn, 1);
    check("rst_grant", grant, 0);
    check("rst_outs", {done, rxdv, pop, err, m_if.tx_dv}, 0);
    check("rst_rxword", rxw, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word from requester 0
    a_tx = n_txdv; a_rx = rx_log.size(); a_g = gnt_log.size();
    base[0] = 16'hA5C3 - 16'(pop_cnt[0]);
    len[3:0] = 4'd0;
    req = 2'b01;
    wait_done(1, 300);
    check("t1_csn_at_done", csn, 1);
    req = '0;
    repeat (2) @(negedge clk);
    check("t1_txdv", n_txdv - a_tx, 1);
    check("t1_rxcnt", rx_log.size() - a_rx, 1);
    check("t1_rxword", rx_at(a_rx), 16'hA5C3);
    check("t1_grant", gnt_at(a_g), 2'b01);
    check("t1_cs_low_cycles", last_low, 16);

    // Four-word burst from requester 1
    a_pop = n_pop; a_rx = rx_log.size(); a_g = gnt_log.size();
    a_rise = n_rise;
    base[1] = 16'h0001 - 16'(pop_cnt[1]);
    len[7:4] = 4'd3;
    req = 2'b10;
    wait_done(1, 400);
    req = '0;
    repeat (2) @(negedge clk);
    check("t2_pops", n_pop - a_pop, 4);
    check("t2_rxcnt", rx_log.size() - a_rx, 4);
    for (int i = 0; i < 4; i++)
      check("t2_rxword", rx_at(a_rx + i), 16'(i + 1));
    check("t2_cs_rises", n_rise - a_rise, 1);
    check("t2_grant", gnt_at(a_g), 2'b10);

    // Both requesters held: strict alternation
    a_g = gnt_log.size(); a_h = hrun_log.size();
    base[0] = 16'h1000 - 16'(pop_cnt[0]);
    base[1] = 16'h2000 - 16'(pop_cnt[1]);
    len = '0;
    req = 2'b11;
    wait_done(6, 600);
    req = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++)
      check("t3_grant", gnt_at(a_g + i), (i % 2 == 0) ? 2'b01 : 2'b10);
    check("t3_bursts", hrun_log.size() - a_h, 6);
    for (int i = a_h + 1; i < hrun_log.size(); i++)
      check("t3_cs_high_gap", hrun_log[i], 9);

    // Reset during word 2 of a 4-word burst
    a_tx = n_txdv;
    base[0] = 16'h0010 - 16'(pop_cnt[0]);
    len[3:0] = 4'd3;
    req = 2'b01;
    wait_txdv(a_tx + 2, 300);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_csn", csn, 1);
    check("t4_rst_grant", grant, 0);
    check("t4_rst_outs", {done, rxdv, pop, err, m_if.tx_dv}, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_rx = rx_log.size(); a_g = gnt_log.size();
    base[1] = 16'hBEEF - 16'(pop_cnt[1]);
    len[7:4] = 4'd0;
    req = 2'b10;
    wait_done(1, 300);
    req = '0;
    repeat (2) @(negedge clk);
    check("t4_after_rxword", rx_at(a_rx), 16'hBEEF);
    check("t4_after_grant", gnt_at(a_g), 2'b10);

    // Master not ready for a long time in LOAD
    block_ready = 1'b1;
    @(negedge clk);
    a_tx = n_txdv; a_rx = rx_log.size();
    base[0] = 16'h5555 - 16'(pop_cnt[0]);
    len[3:0] = 4'd0;
    req = 2'b01;
    repeat (60) @(negedge clk);
    check("t5_no_dv_while_busy", n_txdv - a_tx, 0);
    check("t5_cs_low", csn, 0);
    block_ready = 1'b0;
    wait_done(1, 200);
    req = '0;
    repeat (2) @(negedge clk);
    check("t5_one_dv", n_txdv - a_tx, 1);
    check("t5_rxword", rx_at(a_rx), 16'h5555);
    check("dv_without_ready", viol, 0);

`ifdef SPI_XFER_TIMEOUT_EN
    // Suppressed RX: watchdog abort, then the other requester
    begin
      int seen;
      seen = 0;
      a_done = n_done; a_g = gnt_log.size();
      suppress_rx = 1'b1;
      len = '0;
      req = 2'b11;
      for (int c = 0; c < 400 && seen == 0; c++) begin
        @(negedge clk);
        if (err) seen = 1;
      end
      check("to_err_seen", seen, 1);
      check("to_csn", csn, 1);
      check("to_no_done", n_done - a_done, 0);
      suppress_rx = 1'b0;
      req = 2'b01;
      wait_done(1, 300);
      req = '0;
      check("to_first_grant", gnt_at(a_g), 2'b10);
      check("to_next_grant", gnt_at(a_g + 1), 2'b01);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
